// File: rtl/audio_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fifo_pkg
//  Description : Shared helpers for the multi-channel audio FIFO: the
//                entry-width function, the channel slice helper and the
//                overflow-policy mode constants.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_fifo_pkg;

    // Overflow policy selectors for OVERWRITE_ON_FULL
    localparam int FIFO_DROP_NEW      = 0;
    localparam int FIFO_OVERWRITE_OLD = 1;

    // Width of one FIFO entry: all channel samples side by side
    function automatic int entry_width(input int data_width, input int num_channels);
        return data_width * num_channels;
    endfunction

    // LSB position of channel 'chan' inside an entry
    function automatic int chan_lsb(input int data_width, input int chan);
        return chan * data_width;
    endfunction

endpackage : audio_fifo_pkg
`default_nettype wire

// File: rtl/audio_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fifo_ram
//  Description : Simple dual-port RAM, (2**ADDR_WIDTH) x WIDTH, with a
//                registered (synchronous) read port so it maps to block RAM.
//                The read register has an enable and a synchronous reset so
//                the FIFO head can hold its value and reads 0 after reset.
//                A read of the address being written returns the old data.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_fifo_ram #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [0:c_depth-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: storage is never cleared, only overwritten
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered output, resettable output latch of the RAM
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : audio_fifo_ram
`default_nettype wire

// File: rtl/audio_sync_fifo_mc.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sync_fifo_mc
//  Description : Multi-channel show-ahead synchronous FIFO. Holds up to
//                2**ADDR_WIDTH entries of NUM_CHANNELS samples each, with a
//                full-range word count, programmable almost flags, sticky
//                overflow/underflow and a selectable overflow policy.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_sync_fifo_mc
    import audio_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int NUM_CHANNELS       = 2,
    parameter int ADDR_WIDTH         = 7,
    parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int OVERWRITE_ON_FULL  = FIFO_DROP_NEW
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          write_en,
    input  logic [entry_width(DATA_WIDTH, NUM_CHANNELS)-1:0] write_data,
    input  logic                                          read_en,
    output logic [entry_width(DATA_WIDTH, NUM_CHANNELS)-1:0] read_data,
    input  logic                                          clear_errors,
    output logic                                          fifo_is_empty,
    output logic                                          fifo_is_full,
    output logic                                          almost_empty,
    output logic                                          almost_full,
    output logic [ADDR_WIDTH:0]                           words_used,
    output logic                                          overflow,
    output logic                                          underflow
);

    localparam int                  c_width   = entry_width(DATA_WIDTH, NUM_CHANNELS);
    localparam int                  c_depth   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_cnt_max = (ADDR_WIDTH+1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_af_lvl  = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ae_lvl  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);
    localparam logic                c_ovw     = (OVERWRITE_ON_FULL == FIFO_OVERWRITE_OLD);

    // Elaboration-time parameter sanity checks
    generate
        if (!((ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL) && (ALMOST_FULL_LEVEL <= c_depth))) begin : g_bad_levels
            $error("audio_sync_fifo_mc: need ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= depth");
        end
        if (NUM_CHANNELS < 1) begin : g_bad_channels
            $error("audio_sync_fifo_mc: NUM_CHANNELS must be at least 1");
        end
    endgenerate

    // Registered state
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q, aempty_q, afull_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  byp_sel_q;
    logic [c_width-1:0]    byp_data_q;

    // Per-cycle decisions
    logic                  w_push, w_pop, w_overwrite, w_adv_rd, w_bypass;
    logic                  w_ovf_evt, w_udf_evt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [c_width-1:0]    w_ram_rdata;

    // Decide push/pop, the next pointers/count and the sticky flag updates
    always_comb begin
        w_push      = write_en & (~full_q | read_en | c_ovw);
        w_pop       = read_en & ~empty_q;
        // Overwrite-oldest: the write lands on the head slot, so the head moves too
        w_overwrite = full_q & write_en & ~read_en & c_ovw;
        w_adv_rd    = w_pop | w_overwrite;

        w_rd_ptr_next = rd_ptr_q + ADDR_WIDTH'(w_adv_rd);
        wr_ptr_d      = w_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d      = w_rd_ptr_next;

        // The new entry becomes the head when it lands on the next head slot;
        // the RAM cannot return it yet, so it is forwarded through a register.
        w_bypass = w_push & (empty_q | (wr_ptr_q == w_rd_ptr_next));

        count_d = count_q;
        if (w_push && !w_adv_rd) begin
            count_d = count_q + c_cnt_one;
        end else if (w_adv_rd && !w_push) begin
            count_d = count_q - c_cnt_one;
        end

        w_ovf_evt = full_q & write_en & ~read_en;
        w_udf_evt = empty_q & read_en;
        // A new error event wins over a simultaneous clear
        ovf_d = (ovf_q & ~clear_errors) | w_ovf_evt;
        udf_d = (udf_q & ~clear_errors) | w_udf_evt;
    end

    // Pointer, count, status flag and bypass registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            aempty_q  <= 1'b1;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            byp_sel_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == c_cnt_max);
            aempty_q  <= (count_d <= c_ae_lvl);
            afull_q   <= (count_d >= c_af_lvl);
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            // Head source only changes when the head itself may change
            if (w_push || w_adv_rd) begin
                byp_sel_q <= w_bypass;
            end
        end
    end

    // Forwarded entry for the write-to-read bypass (datapath only, no reset)
    always_ff @(posedge clk) begin
        if (w_bypass) begin
            byp_data_q <= write_data;
        end
    end

    audio_fifo_ram #(
        .WIDTH      (c_width),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_push & ~reset),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (write_data),
        .rd_en_i   (w_push | w_adv_rd),
        .rd_addr_i (w_rd_ptr_next),
        .rd_data_o (w_ram_rdata)
    );

    assign read_data     = byp_sel_q ? byp_data_q : w_ram_rdata;
    assign fifo_is_empty = empty_q;
    assign fifo_is_full  = full_q;
    assign almost_empty  = aempty_q;
    assign almost_full   = afull_q;
    assign words_used    = count_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule : audio_sync_fifo_mc
`default_nettype wire

// File: tb/tb_audio_sync_fifo_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_sync_fifo_mc
//  Description : Self-checking bench for audio_sync_fifo_mc. Three instances
//                share one stimulus: drop-new (2x32), overwrite-old (2x32)
//                and drop-new (4x16). Each is compared every cycle against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_sync_fifo_mc;
    import audio_fifo_pkg::*;

    localparam int D  = 128;
    localparam int AF = 124;
    localparam int AE = 4;

    logic        clk = 1'b0;
    logic        reset, write_en, read_en, clear_errors;
    logic [63:0] write_data;

    logic [63:0] rd0, rd1, rd2;
    logic        e0, f0, ae0, af0, ov0, un0;
    logic        e1, f1, ae1, af1, ov1, un1;
    logic        e2, f2, ae2, af2, ov2, un2;
    logic [7:0]  wu0, wu1, wu2;

    always #5 clk = ~clk;

    audio_sync_fifo_mc #(.DATA_WIDTH(32), .NUM_CHANNELS(2), .OVERWRITE_ON_FULL(FIFO_DROP_NEW)) dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd0), .clear_errors(clear_errors),
        .fifo_is_empty(e0), .fifo_is_full(f0), .almost_empty(ae0), .almost_full(af0),
        .words_used(wu0), .overflow(ov0), .underflow(un0));

    audio_sync_fifo_mc #(.DATA_WIDTH(32), .NUM_CHANNELS(2), .OVERWRITE_ON_FULL(FIFO_OVERWRITE_OLD)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd1), .clear_errors(clear_errors),
        .fifo_is_empty(e1), .fifo_is_full(f1), .almost_empty(ae1), .almost_full(af1),
        .words_used(wu1), .overflow(ov1), .underflow(un1));

    audio_sync_fifo_mc #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .OVERWRITE_ON_FULL(FIFO_DROP_NEW)) dut2 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd2), .clear_errors(clear_errors),
        .fifo_is_empty(e2), .fifo_is_full(f2), .almost_empty(ae2), .almost_full(af2),
        .words_used(wu2), .overflow(ov2), .underflow(un2));

    // Reference model: q0 = drop-new policy, q1 = overwrite-old policy
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit          mo0, mu0, mo1, mu1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs in force at that edge
    task automatic model_edge();
        int n0, n1;
        n0 = q0.size();
        n1 = q1.size();
        if (reset) begin
            q0.delete();
            q1.delete();
            mo0 = 0; mu0 = 0; mo1 = 0; mu1 = 0;
        end else begin
            if (read_en && n0 != 0) void'(q0.pop_front());
            if (write_en && (n0 != D || read_en)) q0.push_back(write_data);
            mo0 = (mo0 && !clear_errors) || (write_en && !read_en && n0 == D);
            mu0 = (mu0 && !clear_errors) || (read_en && n0 == 0);

            if (read_en && n1 != 0) void'(q1.pop_front());
            if (write_en) begin
                if (q1.size() == D) void'(q1.pop_front());
                q1.push_back(write_data);
            end
            mo1 = (mo1 && !clear_errors) || (write_en && !read_en && n1 == D);
            mu1 = (mu1 && !clear_errors) || (read_en && n1 == 0);
        end
    endtask

    task automatic check_dut(input string p, input logic e, input logic f, input logic ae,
                             input logic af, input logic [7:0] wu, input logic ov, input logic un,
                             input logic [63:0] rd, input int n, input logic [63:0] head,
                             input bit mo, input bit mu, input bit per_chan);
        check_eq({p, "_empty"},  64'(e),  64'(n == 0));
        check_eq({p, "_full"},   64'(f),  64'(n == D));
        check_eq({p, "_aempty"}, 64'(ae), 64'(n <= AE));
        check_eq({p, "_afull"},  64'(af), 64'(n >= AF));
        check_eq({p, "_words"},  64'(wu), 64'(n));
        check_eq({p, "_ovf"},    64'(ov), 64'(mo));
        check_eq({p, "_udf"},    64'(un), 64'(mu));
        if (n != 0) begin
            if (per_chan) begin
                for (int c = 0; c < 4; c++)
                    check_eq($sformatf("%s_ch%0d", p, c), 64'(rd[chan_lsb(16, c) +: 16]),
                             64'(head[chan_lsb(16, c) +: 16]));
            end else begin
                check_eq({p, "_data"}, rd, head);
            end
        end
    endtask

    task automatic tick();
        logic [63:0] h0, h1;
        @(posedge clk);
        model_edge();
        #1;
        h0 = (q0.size() != 0) ? q0[0] : 64'd0;
        h1 = (q1.size() != 0) ? q1[0] : 64'd0;
        check_dut("d0", e0, f0, ae0, af0, wu0, ov0, un0, rd0, q0.size(), h0, mo0, mu0, 1'b0);
        check_dut("d1", e1, f1, ae1, af1, wu1, ov1, un1, rd1, q1.size(), h1, mo1, mu1, 1'b0);
        check_dut("d2", e2, f2, ae2, af2, wu2, ov2, un2, rd2, q0.size(), h0, mo0, mu0, 1'b1);
    endtask

    task automatic step(input logic we, input logic re, input logic [63:0] wd, input logic clr);
        write_en     = we;
        read_en      = re;
        write_data   = wd;
        clear_errors = clr;
        tick();
    endtask

    function automatic logic [63:0] chan_pat(input int seq);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 4; c++)
            v[chan_lsb(16, c) +: 16] = {c[3:0], seq[11:0]};
        return v;
    endfunction

    initial begin
        int wr_cnt, rd_cnt;
        reset = 1'b1; write_en = 1'b0; read_en = 1'b0; clear_errors = 1'b0; write_data = '0;
        tick();
        tick();
        check_eq("rst_rdata0", rd0, 64'd0);
        check_eq("rst_rdata2", rd2, 64'd0);
        reset = 1'b0;

        // Fill with 0..127, no reads
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 64'(i), 1'b0);
        check_eq("fill_full", 64'(f0), 64'd1);
        check_eq("fill_words", 64'(wu0), 64'd128);

        // Sustained read+write at full
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
        check_eq("rw_full_ovf", 64'(ov0), 64'd0);

        // One extra write at full: policies diverge
        step(1'b1, 1'b0, 64'hDEAD, 1'b0);
        check_eq("drop_ovf", 64'(ov0), 64'd1);
        check_eq("ovw_words", 64'(wu1), 64'd128);

        // Drain everything plus two reads on empty
        for (int i = 0; i < D + 2; i++) step(1'b0, 1'b1, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'd0, 1'b0);
        check_eq("sticky_udf", 64'(un0), 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        check_eq("clear_udf", 64'(un0), 64'd0);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        check_eq("set_wins", 64'(un0), 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b1);

        // Show-ahead, one-cycle latency
        step(1'b1, 1'b0, 64'hAAAA_5555, 1'b0);
        check_eq("sa_data", rd0, 64'hAAAA_5555);
        check_eq("sa_empty", 64'(e0), 64'd0);
        step(1'b0, 1'b1, 64'd0, 1'b0);
        check_eq("sa_pop_empty", 64'(e0), 64'd1);

        // Read+write on empty
        step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
        check_eq("rw_empty_words", 64'(wu0), 64'd1);
        check_eq("rw_empty_udf", 64'(un0), 64'd1);
        step(1'b0, 1'b1, 64'd0, 1'b1);

        // Reset at count 50 coincident with a write
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, chan_pat(i), 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b0, 64'hFFFF, 1'b0);
        reset = 1'b0;
        check_eq("mid_rst_words", 64'(wu0), 64'd0);
        check_eq("mid_rst_rdata", rd2, 64'd0);

        // 200-write / 200-read channel-pattern stream, bounded
        wr_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < 2000 && (wr_cnt < 200 || rd_cnt < 200); i++) begin
            logic we, re;
            we = (wr_cnt < 200) && ($urandom_range(0, 3) != 0);
            re = (rd_cnt < 200) && ($urandom_range(0, 2) != 0);
            if (re && q0.size() != 0) rd_cnt++;
            if (we) begin
                step(1'b1, re, chan_pat(wr_cnt + 1000), 1'b0);
                wr_cnt++;
            end else begin
                step(1'b0, re, 64'd0, 1'b0);
            end
        end
        check_eq("stream_done", 64'(rd_cnt), 64'd200);

        // Free-running random traffic with shifting bias, clears and rare resets
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            reset = ($urandom_range(0, 999) == 0);
            step(($urandom_range(0, 9) < 3 + 3 * bias), ($urandom_range(0, 9) < 7 - 3 * bias + (bias == 2 ? 3 : 0)),
                 {$urandom, $urandom}, ($urandom_range(0, 49) == 0));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_audio_sync_fifo_mc
`default_nettype wire
